// File: rtl/mem_io_unit.sv
// Multi-cycle SRAM access unit behind the memory stage: stalls the pipeline per access, returns sign-extended loads.
// Optional last-write forwarding buffer enabled by defining MEM_IO_RAW_BYPASS_EN.
module mem_io_unit #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              ld_byte,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              rd_valid,
  output logic              stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce,
  output logic              sram_oe,
  output logic              sram_we,
  output logic              req_conflict
);

  // state  | meaning
  // IDLE   | waiting for a request; accepts on rd_req/wr_req
  // ACCESS | SRAM strobes asserted, wait_cnt counting down to 0
  // DONE   | single cycle; load result presented, pipeline released
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_t              state_q;
  logic [3:0]          wait_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                is_wr_q;
  logic                byte_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rd_valid_q;
  logic                conflict_q;
  logic                ce_q, oe_q, we_q;
  logic                byp_hit_d;

  function automatic logic [DATA_W-1:0] sext(input logic [DATA_W-1:0] d, input logic is_byte);
    return is_byte ? {{(DATA_W-8){d[7]}}, d[7:0]} : d;
  endfunction

`ifdef MEM_IO_RAW_BYPASS_EN
  logic              buf_vld_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_data_q;

  assign byp_hit_d = buf_vld_q && rd_req && !wr_req && (address == buf_addr_q);
`else
  assign byp_hit_d = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      byte_q     <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      conflict_q <= 1'b0;
      ce_q       <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
`ifdef MEM_IO_RAW_BYPASS_EN
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_req) begin
            // Write wins a simultaneous request; the read is dropped, not retried.
            addr_q     <= address;
            wdata_q    <= write_data;
            byte_q     <= ld_byte;
            is_wr_q    <= 1'b1;
            wait_cnt_q <= WAIT_LOAD;
            ce_q       <= 1'b1;
            we_q       <= 1'b1;
            state_q    <= ACCESS;
            if (rd_req) conflict_q <= 1'b1;
          end else if (byp_hit_d) begin
`ifdef MEM_IO_RAW_BYPASS_EN
            rdata_q    <= sext(buf_data_q, ld_byte);
`endif
            rd_valid_q <= 1'b1;
            is_wr_q    <= 1'b0;
            state_q    <= DONE;
          end else if (rd_req) begin
            addr_q     <= address;
            wdata_q    <= write_data;
            byte_q     <= ld_byte;
            is_wr_q    <= 1'b0;
            wait_cnt_q <= WAIT_LOAD;
            ce_q       <= 1'b1;
            oe_q       <= 1'b1;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt_q == 4'd0) begin
            ce_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            state_q <= DONE;
            if (!is_wr_q) begin
              rdata_q    <= sext(sram_rdata, byte_q);
              rd_valid_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        DONE: begin
`ifdef MEM_IO_RAW_BYPASS_EN
          if (is_wr_q) begin
            buf_vld_q  <= 1'b1;
            buf_addr_q <= addr_q;
            buf_data_q <= wdata_q;
          end
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall         = (state_q == ACCESS) || ((state_q == IDLE) && (rd_req || wr_req));
  assign mem_read_data = rdata_q;
  assign rd_valid      = rd_valid_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_ce       = ce_q;
  assign sram_oe       = oe_q;
  assign sram_we       = we_q;
  assign req_conflict  = conflict_q;

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed, table-driven bench for mem_io_unit (default WAIT_STATES=2).
module tb_mem_io_unit;
  localparam int WS = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_req, wr_req, ld_byte;
  logic [16:0] address;
  logic [11:0] write_data;
  logic [11:0] mem_read_data;
  logic        rd_valid, stall;
  logic [16:0] sram_addr;
  logic [11:0] sram_wdata, sram_rdata;
  logic        sram_ce, sram_oe, sram_we, req_conflict;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        ldb;
    logic [16:0] addr;
    logic [11:0] wdata;
    logic [11:0] rdata;
    logic [11:0] exp_data;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[8];

  mem_io_unit #(.WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .ld_byte(ld_byte),
    .address(address), .write_data(write_data), .mem_read_data(mem_read_data),
    .rd_valid(rd_valid), .stall(stall), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we),
    .req_conflict(req_conflict)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    @(negedge clock);
    rd_req = v.rd; wr_req = v.wr; ld_byte = v.ldb;
    address = v.addr; write_data = v.wdata; sram_rdata = v.rdata;
    #1;
    chk("t0_stall", stall, 1);
    chk("t0_ce", sram_ce, 0);
    for (int k = 1; k <= WS; k++) begin
      @(negedge clock); #1;
      chk("acc_stall", stall, 1);
      chk("acc_ce", sram_ce, 1);
      chk("acc_oe", sram_oe, v.rd & ~v.wr);
      chk("acc_we", sram_we, v.wr);
      chk("acc_addr", sram_addr, v.addr);
      chk("acc_rd_valid", rd_valid, 0);
      if (v.wr) chk("acc_wdata", sram_wdata, v.wdata);
    end
    @(negedge clock); #1;
    chk("done_stall", stall, 0);
    chk("done_ce", sram_ce, 0);
    chk("done_oe", sram_oe, 0);
    chk("done_we", sram_we, 0);
    chk("done_rd_valid", rd_valid, v.exp_valid);
    chk("done_data", mem_read_data, v.exp_data);
    rd_req = 0; wr_req = 0;
    @(negedge clock); #1;
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_stall", stall, 0);
  endtask

  initial begin
    //         rd  wr  ldb addr      wdata    rdata    exp_data valid
    vecs[0] = '{1, 0, 0, 17'h00123, 12'h000, 12'hA5C, 12'hA5C, 1};
    vecs[1] = '{1, 0, 1, 17'h00200, 12'h000, 12'h08F, 12'hF8F, 1};
    vecs[2] = '{1, 0, 1, 17'h00201, 12'h000, 12'h07F, 12'h07F, 1};
    vecs[3] = '{0, 1, 0, 17'h10004, 12'h3C1, 12'h000, 12'h07F, 0};
    vecs[4] = '{1, 0, 0, 17'h1FFFF, 12'h000, 12'hFFF, 12'hFFF, 1};
    vecs[5] = '{1, 0, 1, 17'h0ABCD, 12'h000, 12'h180, 12'hF80, 1};
    vecs[6] = '{1, 0, 1, 17'h00002, 12'h000, 12'h800, 12'h000, 1};
    vecs[7] = '{1, 0, 0, 17'h00003, 12'h000, 12'h800, 12'h800, 1};

    reset = 1; rd_req = 0; wr_req = 0; ld_byte = 0;
    address = '0; write_data = '0; sram_rdata = '0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_data", mem_read_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_conflict", req_conflict, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_strobes", {sram_ce, sram_oe, sram_we}, 0);
    reset = 0;

    for (int i = 0; i < 8; i++) do_txn(vecs[i]);
    chk("no_conflict", req_conflict, 0);

    // Back-to-back: request held through DONE must not be accepted until the cycle after.
    @(negedge clock);
    rd_req = 1; ld_byte = 0; address = 17'h00010; sram_rdata = 12'h111;
    #1; chk("b2b_t0_stall", stall, 1);
    @(negedge clock); #1; chk("b2b_t1_ce", sram_ce, 1);
    @(negedge clock); #1; chk("b2b_t2_ce", sram_ce, 1);
    @(negedge clock); #1;
    chk("b2b_done_stall", stall, 0);
    chk("b2b_done_valid", rd_valid, 1);
    chk("b2b_done_data", mem_read_data, 12'h111);
    address = 17'h00011; sram_rdata = 12'h222;
    @(negedge clock); #1;
    chk("b2b_t0b_stall", stall, 1);
    chk("b2b_t0b_ce", sram_ce, 0);
    chk("b2b_t0b_valid", rd_valid, 0);
    @(negedge clock); #1; chk("b2b_t1b_ce", sram_ce, 1); chk("b2b_t1b_addr", sram_addr, 17'h00011);
    @(negedge clock); #1; chk("b2b_t2b_ce", sram_ce, 1);
    @(negedge clock); #1;
    chk("b2b_doneb_valid", rd_valid, 1);
    chk("b2b_doneb_data", mem_read_data, 12'h222);
    rd_req = 0;

    do_txn('{1, 1, 0, 17'h00300, 12'h0AA, 12'h555, 12'h222, 0});
    chk("conflict_set", req_conflict, 1);
    do_txn('{1, 0, 0, 17'h00301, 12'h000, 12'h321, 12'h321, 1});
    chk("conflict_sticky", req_conflict, 1);

    // Reset in T1 of a read
    @(negedge clock);
    rd_req = 1; ld_byte = 0; address = 17'h00400; sram_rdata = 12'h7E7;
    #1; chk("rm_t0_stall", stall, 1);
    @(negedge clock); #1;
    chk("rm_t1_ce", sram_ce, 1);
    chk("rm_t1_oe", sram_oe, 1);
    reset = 1; rd_req = 0;
    @(negedge clock); #1;
    chk("rm_strobes", {sram_ce, sram_oe, sram_we}, 0);
    chk("rm_rd_valid", rd_valid, 0);
    chk("rm_data", mem_read_data, 0);
    chk("rm_conflict", req_conflict, 0);
    chk("rm_stall", stall, 0);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("rm_after_valid", rd_valid, 0);
      chk("rm_after_ce", sram_ce, 0);
    end
    do_txn('{1, 0, 1, 17'h00401, 12'h000, 12'h0C3, 12'hFC3, 1});

`ifdef MEM_IO_RAW_BYPASS_EN
    do_txn('{0, 1, 0, 17'h00040, 12'h155, 12'h000, 12'hFC3, 0});
    @(negedge clock);
    rd_req = 1; ld_byte = 0; address = 17'h00040; sram_rdata = 12'h000;
    #1; chk("byp_t0_stall", stall, 1);
    @(negedge clock); #1;
    chk("byp_t1_valid", rd_valid, 1);
    chk("byp_t1_data", mem_read_data, 12'h155);
    chk("byp_t1_strobes", {sram_ce, sram_oe, sram_we}, 0);
    chk("byp_t1_stall", stall, 0);
    rd_req = 0;
    @(negedge clock); #1; chk("byp_idle_valid", rd_valid, 0);
    do_txn('{1, 0, 0, 17'h00041, 12'h000, 12'h0F0, 12'h0F0, 1});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_io_unit.md
# mem_io_unit

Memory I/O unit sitting directly downstream of the memory pipeline stage. It consumes the 17-bit address and 12-bit store data produced there and performs a multi-cycle access to the external data SRAM. It returns sign-extended load data to the MEM/WB data input path, and stalls the pipeline for the duration of every access.

## Interface
Parameters:
- `WAIT_STATES`, default 2: SRAM access cycles per transfer; legal range 1–15.
- `ADDR_W`, default 17: address width; bit 16 is the framebuffer page bit.
- `DATA_W`, default 12: memory word width.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rd_req` in 1: load request from the memory stage; level-held while `stall` is high.
- `wr_req` in 1: store request; level-held while `stall` is high.
- `ld_byte` in 1: load is a byte; sign-extend `sram_rdata[7:0]` to 12 bits.
- `address` in 17: access address.
- `write_data` in 12: store data.
- `mem_read_data` out 12: load result, always sign-extended; held until the next load completes.
- `rd_valid` out 1: one-cycle pulse when `mem_read_data` updates.
- `stall` out 1: holds all pipeline registers upstream of MEM/WB.
- `sram_addr` out 17: external address.
- `sram_wdata` out 12: external write data.
- `sram_rdata` in 12: external read data; sampled on the last access cycle.
- `sram_ce` out 1: chip enable, active-high.
- `sram_oe` out 1: output enable, active-high.
- `sram_we` out 1: write enable, active-high.
- `req_conflict` out 1: sticky flag; set when `rd_req` and `wr_req` are high in the same accepting cycle; cleared only by `reset`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On `wr_req` or `rd_req`: latch `address`, `write_data`, `ld_byte` and the operation type; load `wait_cnt` = `WAIT_STATES`-1; go to ACCESS.
  - If both requests are high, the write wins and `req_conflict` is set. The read is not performed and is not retried.
- ACCESS:
  - `sram_ce`=1 throughout; `sram_we`=1 for writes, `sram_oe`=1 for reads.
  - `sram_addr` and `sram_wdata` are driven from the latched values for the whole state.
  - `wait_cnt` decrements each cycle. When `wait_cnt`==0, go to DONE.
  - For a read, the last ACCESS cycle also captures `sram_rdata`.
- DONE: lasts exactly one cycle.
  - Read: `mem_read_data` updates and `rd_valid`=1.
  - Then return to IDLE. A new request is never accepted in DONE.
- `stall` is combinational: high in IDLE when (`rd_req`|`wr_req`), and high in ACCESS; low in DONE. The pipeline therefore advances out of the request exactly on the DONE cycle.
- Sign extension:
  - `ld_byte`=1 → `{ {4{d[7]}}, d[7:0] }`.
  - `ld_byte`=0 → the full 12-bit word unchanged.
- Requests arriving while in ACCESS or DONE are ignored. Upstream holds them because `stall` was high.

## Timing
- Reset values:
  - state IDLE.
  - `mem_read_data`=0, `rd_valid`=0, `req_conflict`=0.
  - `sram_addr`=0, `sram_wdata`=0.
  - `sram_ce`/`sram_oe`/`sram_we`=0.
- `stall` follows its combinational rule and is 0 while `reset` is held with no request.
- Access latency from request cycle T0:
  - ACCESS spans cycles T1..T`WAIT_STATES`; DONE is cycle T`WAIT_STATES`+1.
  - `stall` is high for `WAIT_STATES`+1 cycles.
  - With the default (2): stall is high in T0–T2, DONE is T3.
- SRAM strobes are registered outputs: they rise at the T1 edge and fall at the DONE edge.
- Back-to-back requests: next acceptance is no earlier than the cycle after DONE. Minimum spacing between accepts is `WAIT_STATES`+2 cycles.
- Reset mid-access: at the next edge, state goes to IDLE and strobes go to 0. No `rd_valid` pulse is produced, and `mem_read_data` is cleared to 0.

## Configuration
- `MEM_IO_RAW_BYPASS_EN` defined:
  - A last-write buffer holds {valid, address, data}. It is written in the DONE cycle of each store, and invalidated on reset.
  - A read in IDLE whose `address` equals the buffered address (with valid set) goes straight to DONE. No SRAM strobes are asserted.
  - Data comes from the buffer with the same `ld_byte` sign-extension rule.
  - `stall` is high for T0 only; DONE is T1.
- `MEM_IO_RAW_BYPASS_EN` undefined: no buffer is built, and every read goes through ACCESS.

## Test plan
- Read, word: `WAIT_STATES`=2, `rd_req` at 0x00123, `ld_byte`=0, `sram_rdata`=0xA5C → strobes high T1–T2, `stall` high T0–T2, `mem_read_data`=0xA5C with `rd_valid` in T3.
- Read, byte: `ld_byte`=1, `sram_rdata`=0x08F → `mem_read_data`=0xF8F; with `sram_rdata`=0x07F → `mem_read_data`=0x07F.
- Write: store 0x3C1 to 0x10004 → `sram_we`=1 and `sram_addr`=0x10004 for 2 cycles, `sram_oe`=0, no `rd_valid`.
- Conflict: `rd_req`=`wr_req`=1 in IDLE → write performed, `req_conflict`=1 and remains 1 until `reset`.
- Reset mid-access: assert `reset` in T1 of a read → strobes 0 next cycle, no `rd_valid`, state IDLE, `mem_read_data`=0.
- Bypass (macro on): store 0x155 to 0x00040, then read 0x00040 with `ld_byte`=0 → `mem_read_data`=0x155 in T1 with no strobes. Read of 0x00041 → full SRAM access.
